// File: rtl/ppu_pal_mux.sv
// ppu_pal_mux: pixel priority mux, sprite-0 hit detection and 32x6 palette RAM.
// Combines bg/sprite palette indices on each visible dot. Looks up the NES colour
// and registers it with a one-clock valid strobe. Also services CPU palette
// reads and writes in the 0x3F00-0x3FFF region.
// Optional feature: define PPU_GRAYSCALE_EN to mask the rendered colour with
// 6'h30 while grayscale_in is set.
module ppu_pal_mux (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       pix_pulse_in,
  input  logic [9:0] nes_x_in,
  input  logic [9:0] nes_y_in,
  input  logic       bg_en_in,
  input  logic       spr_en_in,
  input  logic [3:0] bg_palette_idx_in,
  input  logic [3:0] spr_palette_idx_in,
  input  logic       spr_priority_in,
  input  logic       spr_primary_in,
  input  logic       clr_hit_in,
  input  logic       grayscale_in,
  input  logic [13:0] vram_a_in,
  input  logic [7:0] vram_d_in,
  input  logic       pal_wr_in,
  output logic [7:0] pal_d_out,
  output logic       spr_0_hit_out,
  output logic [5:0] color_out,
  output logic       color_vld_out
);

  // Sprite backdrop slots 0x10/14/18/1C alias the bg backdrop slots.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    pal_mirror = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  logic [31:0][5:0] pal_q, pal_d;
  logic [5:0]       color_q, color_d;
  logic             vld_q, vld_d;
  logic             hit_q, hit_d;

  logic [4:0] cpu_idx;
  logic       wr_hit;
  logic       visible;
  logic       bg_opq, spr_opq;
  logic [4:0] sel_idx;
  logic [5:0] sel_entry;
  logic [5:0] color_sel;
  logic       hit_cond;

  // Bits that carry no meaning for this stage.
  logic unused_bits;
  assign unused_bits = ^{vram_a_in[7:5], vram_d_in[7:6], grayscale_in};

  assign cpu_idx   = pal_mirror(vram_a_in[4:0]);
  assign wr_hit    = pal_wr_in && (vram_a_in[13:8] == 6'h3F);
  assign pal_d_out = {2'b00, pal_q[cpu_idx]};

  // Priority resolution and colour lookup for the current dot.
  always_comb begin
    visible = pix_pulse_in && (nes_x_in < 10'd256) && (nes_y_in < 10'd240);
    bg_opq  = bg_en_in  && (bg_palette_idx_in[1:0]  != 2'b00);
    spr_opq = spr_en_in && (spr_palette_idx_in[1:0] != 2'b00);
    sel_idx = 5'h00;
    if (spr_opq && (!bg_opq || !spr_priority_in))
      sel_idx = {1'b1, spr_palette_idx_in};
    else if (bg_opq)
      sel_idx = {1'b0, bg_palette_idx_in};
    // Lookup reads the pre-write array, so a same-cycle write is seen next clock.
    sel_entry = pal_q[pal_mirror(sel_idx)];
`ifdef PPU_GRAYSCALE_EN
    color_sel = grayscale_in ? (sel_entry & 6'h30) : sel_entry;
`else
    color_sel = sel_entry;
`endif
    hit_cond = visible && bg_opq && spr_opq && spr_primary_in &&
               (nes_x_in != 10'd255);
  end

  // Next-state: palette write, colour register, valid strobe, sticky hit.
  always_comb begin
    pal_d = pal_q;
    if (wr_hit) pal_d[cpu_idx] = vram_d_in[5:0];
    color_d = visible ? color_sel : color_q;
    vld_d   = visible;
    hit_d   = hit_q;
    if (clr_hit_in)    hit_d = 1'b0;
    else if (hit_cond) hit_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pal_q   <= '0;
      color_q <= 6'h00;
      vld_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      pal_q   <= pal_d;
      color_q <= color_d;
      vld_q   <= vld_d;
      hit_q   <= hit_d;
    end
  end

  assign color_out     = color_q;
  assign color_vld_out = vld_q;
  assign spr_0_hit_out = hit_q;

endmodule

// File: doc/ppu_pal_mux.md
# ppu_pal_mux

Pixel priority multiplexer and palette RAM stage of the PPU, directly downstream of the background block (ppu_bg) and the sprite block. On each visible NES dot it combines the 4-bit background and sprite palette indices, resolves priority, and detects sprite-0 hits. It looks up the 6-bit NES system colour in the 32-entry palette RAM and presents it, registered, to the video output stage. It also services CPU reads and writes to the 0x3F00–0x3FFF palette region.

## Interface
- No parameters.
- clk_in  input  1  50MHz system clock.
- rst_n_in  input  1  Reset, asynchronous, active-low.
- pix_pulse_in  input  1  One-clock pulse immediately before nes_x_in changes.
- nes_x_in  input  10  Current NES x coordinate.
- nes_y_in  input  10  Current NES y coordinate.
- bg_en_in  input  1  Background rendering enabled (2001.3).
- spr_en_in  input  1  Sprite rendering enabled (2001.4).
- bg_palette_idx_in  input  4  Background palette index for the current dot.
- spr_palette_idx_in  input  4  Sprite palette index for the current dot.
- spr_priority_in  input  1  1 = sprite behind background.
- spr_primary_in  input  1  Current sprite pixel belongs to OAM sprite 0.
- clr_hit_in  input  1  Clear sprite-0 hit flag (pre-render line start).
- grayscale_in  input  1  2001.0 grayscale bit.
- vram_a_in  input  14  CPU-side 0x2007 VRAM address.
- vram_d_in  input  8  CPU write data.
- pal_wr_in  input  1  CPU 0x2007 write strobe.
- pal_d_out  output  8  Palette read data, {2'b00, entry}.
- spr_0_hit_out  output  1  Sprite-0 hit flag (2002.6).
- color_out  output  6  NES system colour for the last visible dot.
- color_vld_out  output  1  One-clock strobe: color_out updated.

## Operation
- Palette RAM: 32 x 6 flops. Index = vram_a_in[4:0]. When index[4] = 1 and index[1:0] = 0, index[4] is forced to 0, so 0x10/14/18/1C mirror 0x00/04/08/0C.
- Write: pal_wr_in && vram_a_in[13:8] == 6'h3F stores vram_d_in[5:0] at the mirrored index. Any other address is ignored.
- pal_d_out: combinational read of the mirrored index from vram_a_in, with bits [7:6] = 0.
- Visible dot: pix_pulse_in && nes_x_in < 256 && nes_y_in < 240.
- Opacity: bg is opaque when bg_en_in && bg_palette_idx_in[1:0] != 0. Sprite is opaque when spr_en_in && spr_palette_idx_in[1:0] != 0.
- Selection:
  - Neither opaque -> entry 0x00.
  - Sprite only -> {1'b1, spr_idx}.
  - Bg only -> {1'b0, bg_idx}.
  - Both opaque -> sprite if spr_priority_in = 0, else bg.
- Sprite-0 hit: set on a visible dot when both are opaque, spr_primary_in = 1, and nes_x_in != 255. The flag is sticky until clr_hit_in or reset.

## Timing
- Reset: palette RAM all 0; color_out = 6'h00; color_vld_out = 0; spr_0_hit_out = 0.
- Latency: on the clock edge ending a visible-dot pix_pulse_in cycle, color_out is loaded and color_vld_out = 1 for exactly one clock. Otherwise color_vld_out = 0 and color_out holds.
- A palette write on the same cycle as a lookup of that entry: the lookup uses the old value. The new value is visible from the next clock.
- spr_0_hit_out rises on the same edge as the color_out update for the hit dot.
- clr_hit_in and a hit condition in the same cycle: clear wins, and the flag is 0.
- Reset asserted mid-line clears all state immediately. After release, output resumes on the next visible pix_pulse_in.

## Configuration
- PPU_GRAYSCALE_EN defined: when grayscale_in = 1, color_out = selected_entry & 6'h30. This applies to the rendered path only; pal_d_out is unaffected.
- Undefined: grayscale_in is ignored, and color_out is always the raw palette entry.

## Test plan
- Reset -> all outputs 0. Read 0x3F00..0x3F1F -> pal_d_out = 0x00 for every entry.
- Write 0x3F10 = 0x2A, then read 0x3F00 -> 0x2A. Write 0x3F11 = 0x15 -> 0x3F01 unchanged, 0x3F11 reads 0x15.
- Set entry 0x05 = 0x21 and 0x11 = 0x0F. Apply bg_idx = 5, spr_idx = 1, priority = 0 -> color_out = 0x0F. With priority = 1 -> 0x21. With both transparent -> entry 0x00.
- Sprite-0 hit: both opaque with spr_primary_in at x = 100 -> flag set that edge. At x = 255 -> no set. clr_hit_in together with a hit -> flag 0.
- bg_en_in = 0 with bg_idx = 3 and sprite transparent -> backdrop colour. Non-visible dot (x = 300) -> color_vld_out stays 0.
- With PPU_GRAYSCALE_EN, entry 0x2D and grayscale_in = 1 -> color_out = 0x20. Without the macro -> 0x2D.
